quad_gpio_in: RTL

//  Wishbone-slave GPIO input port: the read-side counterpart to the GPIO output block on the quad SoC bus.

---
 rtl/quad_gpio_in_if.sv | 25 ++
 rtl/quad_gpio_in.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/quad_gpio_in_if.sv
// Wishbone-style register bus between the CPU master and the quad_gpio_in slave.
//
// Handshake: the master raises i_wb_cyc (address, write data and i_wb_we stable
// with it) and holds it until it sees o_wb_ack. The slave answers every cycle
// with exactly one o_wb_ack pulse one clock later. o_wb_dat carries read data
// while o_wb_ack is high. The master drops i_wb_cyc after the ack; ack is never
// high on two consecutive cycles, so a held cyc is treated as a new access.
interface quad_gpio_in_if;
   logic [31:0] i_wb_addr;
   logic [31:0] i_wb_dat;
   logic        i_wb_we;
   logic        i_wb_cyc;
   logic [31:0] o_wb_dat;
   logic        o_wb_ack;

   modport master (
      output i_wb_addr, i_wb_dat, i_wb_we, i_wb_cyc,
      input  o_wb_dat, o_wb_ack
   );

   modport slave (
      input  i_wb_addr, i_wb_dat, i_wb_we, i_wb_cyc,
      output o_wb_dat, o_wb_ack
   );
endinterface

// File: rtl/quad_gpio_in.sv
// GPIO input port: 2-FF synchronizer, per-bit debounce filter, sticky
// rising/falling edge status (write-1-to-clear) and one masked level interrupt.
module quad_gpio_in #(
   parameter int WIDTH    = 8,
   parameter int DEBOUNCE = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   quad_gpio_in_if.slave    wb,
   input  logic [WIDTH-1:0] i_gpio,
   output logic             o_irq
);

   localparam logic [7:0] ADDR_DATA    = 8'h00;
   localparam logic [7:0] ADDR_RISE_EN = 8'h04;
   localparam logic [7:0] ADDR_FALL_EN = 8'h08;
   localparam logic [7:0] ADDR_STATUS  = 8'h0C;
   localparam logic [7:0] ADDR_IRQ_EN  = 8'h10;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_nxt;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] status;
   logic [WIDTH-1:0] status_nxt;
   logic [WIDTH-1:0] irq_en;
   logic [WIDTH-1:0] events;
   logic [WIDTH-1:0] w1c;
   logic [7:0]       addr;
   logic             wr_en;
   logic             rd_en;
   logic [31:0]      rd_data;
   logic             unused_bus;

   // Only the low address byte is decoded; data bits above WIDTH are ignored.
   assign addr       = wb.i_wb_addr[7:0];
   assign unused_bus = ^{wb.i_wb_addr[31:8], wb.i_wb_dat};

   // A new access is recognised only while ack is low, so each access commits once.
   assign wr_en = wb.i_wb_cyc &  wb.i_wb_we & ~wb.o_wb_ack;
   assign rd_en = wb.i_wb_cyc & ~wb.i_wb_we & ~wb.o_wb_ack;

   generate
      if (DEBOUNCE == 0) begin : g_bypass
         // Filter bypassed: the synchronized level is accepted every cycle.
         always_comb stable_nxt = sync2;
      end else begin : g_filter
         localparam int             CW       = $clog2(DEBOUNCE + 1);
         localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

         logic [CW-1:0] cnt     [WIDTH];
         logic [CW-1:0] cnt_nxt [WIDTH];

         // A differing level must persist DEBOUNCE cycles before it is accepted.
         always_comb begin
            stable_nxt = stable;
            for (int b = 0; b < WIDTH; b++) begin
               cnt_nxt[b] = '0;
               if (sync2[b] == stable[b]) begin
                  cnt_nxt[b] = '0;
               end else if (cnt[b] == CNT_LAST) begin
                  stable_nxt[b] = sync2[b];
                  cnt_nxt[b]    = '0;
               end else begin
                  cnt_nxt[b] = cnt[b] + 1'b1;
               end
            end
         end

         // Debounce counters.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
            end else begin
               cnt <= cnt_nxt;
            end
         end
      end
   endgenerate

   // Edge events come from the debounced level changing on this edge; a new
   // event beats a simultaneous write-1-to-clear of the same bit.
   always_comb begin
      events     = ( stable_nxt & ~stable & rise_en) |
                   (~stable_nxt &  stable & fall_en);
      w1c        = (wr_en && addr == ADDR_STATUS) ? wb.i_wb_dat[WIDTH-1:0] : '0;
      status_nxt = (status & ~w1c) | events;
   end

   // Read mux; registers are zero-extended and unmapped addresses read 0.
   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_DATA:    rd_data = 32'(stable);
         ADDR_RISE_EN: rd_data = 32'(rise_en);
         ADDR_FALL_EN: rd_data = 32'(fall_en);
         ADDR_STATUS:  rd_data = 32'(status);
         ADDR_IRQ_EN:  rd_data = 32'(irq_en);
         default:      rd_data = '0;
      endcase
   end

   // Input synchronizer, debounced level and sticky status.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         status <= '0;
      end else begin
         sync1  <= i_gpio;
         sync2  <= sync1;
         stable <= stable_nxt;
         status <= status_nxt;
      end
   end

   // Enable/mask registers written by the bus.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rise_en <= '0;
         fall_en <= '0;
         irq_en  <= '0;
      end else if (wr_en) begin
         case (addr)
            ADDR_RISE_EN: rise_en <= wb.i_wb_dat[WIDTH-1:0];
            ADDR_FALL_EN: fall_en <= wb.i_wb_dat[WIDTH-1:0];
            ADDR_IRQ_EN:  irq_en  <= wb.i_wb_dat[WIDTH-1:0];
            default: ;
         endcase
      end
   end

   // Bus ack pulse and read data, which holds until the next read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wb.o_wb_ack <= 1'b0;
         wb.o_wb_dat <= '0;
      end else begin
         wb.o_wb_ack <= wb.i_wb_cyc & ~wb.o_wb_ack;
         if (rd_en) wb.o_wb_dat <= rd_data;
      end
   end

   // Registered level interrupt from masked status.
   always_ff @(posedge i_clk) begin
      if (i_rst) o_irq <= 1'b0;
      else       o_irq <= |(status & irq_en);
   end

endmodule
